// File: rtl/ssp_pkg.sv
// ============================================================================
// ssp_pkg : shared types and sizing helpers for the SSP serial engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package ssp_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_FSS   = 2'd1,
      TX_SHIFT = 2'd2
   } tx_state_e;

   localparam int SYNC_DEPTH = 2;

   // Bit counter must hold 0..data_w; divider counts one full SSPCLKOUT period.
   function automatic int bit_cnt_w(input int data_w);
      return $clog2(data_w + 1);
   endfunction

   function automatic int div_cnt_w(input int clk_div);
      return $clog2(2 * clk_div);
   endfunction

endpackage : ssp_pkg

`default_nettype wire

// File: rtl/ssp_sync.sv
// ============================================================================
// ssp_sync : multi-flop synchroniser for one asynchronous input, sync reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module ssp_sync
   import ssp_pkg::*;
#(
   parameter int STAGES = SYNC_DEPTH
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : ssp_sync

`default_nettype wire

// File: rtl/ssp_engine.sv
// ============================================================================
// ssp_engine : SSP serial TX (divided clock, frame pulse) and framed RX engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module ssp_engine
   import ssp_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 2,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              rx_frame_err,
   input  logic              SSPCLKIN,
   input  logic              SSPFSSIN,
   input  logic              SSPRXD,
   output logic              SSPCLKOUT,
   output logic              SSPFSSOUT,
   output logic              SSPTXD,
   output logic              SSPOE_B
);

   localparam int BIT_W = bit_cnt_w(DATA_W);
   localparam int DIV_W = div_cnt_w(CLK_DIV);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);

   tx_state_e         state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d, div_inc;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d, tx_sh_adv;
   logic [BIT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic              clkout_q, clkout_d;
   logic              fss_q, fss_d;
   logic              txd_q, txd_d;
   logic              oe_b_q, oe_b_d;
   logic              tx_first, clk_fall;

   logic              sclk_sync, sfss_sync, srxd_sync;
   logic              sclk_prev_q, sclk_rise;
   logic              armed_q, armed_d;
   logic [BIT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_sh_nxt;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_ovr_q, rx_ovr_d;
   logic              rx_ferr_q, rx_ferr_d;

   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign tx_first  = tx_sh_q[0];
         assign tx_sh_adv = {1'b0, tx_sh_q[DATA_W-1:1]};
         assign rx_sh_nxt = {srxd_sync, rx_sh_q[DATA_W-1:1]};
      end else begin : g_msb_first
         assign tx_first  = tx_sh_q[DATA_W-1];
         assign tx_sh_adv = {tx_sh_q[DATA_W-2:0], 1'b0};
         assign rx_sh_nxt = {rx_sh_q[DATA_W-2:0], srxd_sync};
      end
   endgenerate

   assign div_inc  = div_q + DIV_W'(1);
   assign clk_fall = (div_q == DIV_LAST);

   // Every TX output change is made at the SSPCLKOUT falling edge (clk_fall).
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      tx_sh_d  = tx_sh_q;
      tx_cnt_d = tx_cnt_q;
      clkout_d = clkout_q;
      fss_d    = fss_q;
      txd_d    = txd_q;
      oe_b_d   = oe_b_q;
      if (state_q != TX_IDLE) begin
         div_d    = clk_fall ? '0 : div_inc;
         clkout_d = clk_fall ? 1'b0 : (div_inc >= DIV_HIGH);
      end
      case (state_q)
         TX_IDLE: begin
            if (tx_valid) begin
               state_d  = TX_FSS;
               tx_sh_d  = tx_data;
               div_d    = '0;
               clkout_d = 1'b0;
               fss_d    = 1'b1;
               txd_d    = 1'b0;
               oe_b_d   = 1'b0;
            end
         end
         TX_FSS: begin
            if (clk_fall) begin
               state_d  = TX_SHIFT;
               fss_d    = 1'b0;
               txd_d    = tx_first;
               tx_sh_d  = tx_sh_adv;
               tx_cnt_d = '0;
            end
         end
         TX_SHIFT: begin
            if (clk_fall) begin
               if (tx_cnt_q == LAST_BIT) begin
                  state_d = TX_IDLE;
                  txd_d   = 1'b0;
                  oe_b_d  = 1'b1;
               end else begin
                  tx_cnt_d = tx_cnt_q + BIT_W'(1);
                  txd_d    = tx_first;
                  tx_sh_d  = tx_sh_adv;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= TX_IDLE;
         div_q    <= '0;
         tx_sh_q  <= '0;
         tx_cnt_q <= '0;
         clkout_q <= 1'b0;
         fss_q    <= 1'b0;
         txd_q    <= 1'b0;
         oe_b_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         tx_sh_q  <= tx_sh_d;
         tx_cnt_q <= tx_cnt_d;
         clkout_q <= clkout_d;
         fss_q    <= fss_d;
         txd_q    <= txd_d;
         oe_b_q   <= oe_b_d;
      end
   end

   ssp_sync u_sync_clk (.clk_i(PCLK), .rst_i(PRESET), .d_i(SSPCLKIN), .q_o(sclk_sync));
   ssp_sync u_sync_fss (.clk_i(PCLK), .rst_i(PRESET), .d_i(SSPFSSIN), .q_o(sfss_sync));
   ssp_sync u_sync_rxd (.clk_i(PCLK), .rst_i(PRESET), .d_i(SSPRXD),   .q_o(srxd_sync));

   assign sclk_rise = sclk_sync & ~sclk_prev_q;

   // A word completing in the same cycle as a consume keeps rx_valid high.
   always_comb begin
      armed_d    = armed_q;
      rx_cnt_d   = rx_cnt_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      rx_ferr_d  = 1'b0;
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (sclk_rise) begin
         if (sfss_sync) begin
            armed_d  = 1'b1;
            rx_cnt_d = '0;
            rx_ferr_d = armed_q && (rx_cnt_q != '0);
         end else if (armed_q) begin
            rx_sh_d  = rx_sh_nxt;
            rx_cnt_d = rx_cnt_q + BIT_W'(1);
            if (rx_cnt_q == LAST_BIT) begin
               armed_d    = 1'b0;
               rx_cnt_d   = '0;
               rx_data_d  = rx_sh_nxt;
               rx_valid_d = 1'b1;
               if (rx_valid_q && !rx_ready) begin
                  rx_ovr_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sclk_prev_q <= 1'b0;
         armed_q     <= 1'b0;
         rx_cnt_q    <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_ovr_q    <= 1'b0;
         rx_ferr_q   <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_sync;
         armed_q     <= armed_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         rx_ovr_q    <= rx_ovr_d;
         rx_ferr_q   <= rx_ferr_d;
      end
   end

   assign tx_ready     = (state_q == TX_IDLE);
   assign SSPCLKOUT    = clkout_q;
   assign SSPFSSOUT    = fss_q;
   assign SSPTXD       = txd_q;
   assign SSPOE_B      = oe_b_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_overrun   = rx_ovr_q;
   assign rx_frame_err = rx_ferr_q;

endmodule : ssp_engine

`default_nettype wire

// File: doc/ssp_engine.md
# ssp_engine

Parametrised SSP serial transmit/receive engine in the PCLK domain: it serialises words from the transmit FIFO side onto SSPTXD with a generated, divided SSPCLKOUT and a one-bit-period SSPFSSOUT frame pulse, and it deserialises SSPRXD framed by an external SSPCLKIN/SSPFSSIN into a held receive word with a valid/ready handshake. Compared with the first-generation transmit/receive logic, it adds configurable word width, bit order and clock divide. It also adds synchronised external inputs, reset, back-pressure, overrun and frame-error detection. It sits between the TX/RX FIFOs and the SSP pins.

## Interface
Parameters:
- DATA_W, 8: word width in bits, legal 4..16.
- CLK_DIV, 2: PCLK cycles per SSPCLKOUT half-period, legal ≥2.
- LSB_FIRST, 0: 0 = MSB first, 1 = LSB first, for both TX and RX.

Ports:
- PCLK  in  1  sole clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- tx_valid  in  1  TX FIFO has a word.
- tx_data  in  DATA_W  word to send; sampled only on accept.
- tx_ready  out  1  engine idle and able to accept.
- rx_data  out  DATA_W  last received word; held until the next word completes.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer takes rx_data when rx_valid is high.
- rx_overrun  out  1  sticky; a word completed while rx_valid was high and not accepted.
- rx_frame_err  out  1  one-cycle pulse; SSPFSSIN was sampled high mid-word.
- SSPCLKIN, SSPFSSIN, SSPRXD  in  1 each  external serial clock, frame, and data; asynchronous.
- SSPCLKOUT, SSPFSSOUT, SSPTXD  out  1 each  serial clock, frame, and data; registered.
- SSPOE_B  out  1  active-low output enable; low while a frame is being driven.

## Operation
TX state machine (IDLE, FSS, SHIFT):
- In IDLE, tx_ready is 1. When tx_valid and tx_ready are both high, tx_data loads into the shift register and the state moves to FSS.
- All TX output changes happen on SSPCLKOUT falling edges.
- In FSS, SSPFSSOUT is 1 for one SSPCLKOUT period, and the divider runs.
- At the next falling edge the state moves to SHIFT. SSPFSSOUT goes to 0 and SSPTXD presents the first bit (bit DATA_W-1, or bit 0 when LSB_FIRST=1).
- In SHIFT, one bit is presented per falling edge, for DATA_W bits.
- At the falling edge that ends the last bit, the state returns to IDLE. SSPOE_B goes to 1, SSPTXD goes to 0 and SSPCLKOUT stays 0.
- tx_valid held high gives back-to-back frames, separated by one IDLE cycle.

RX path:
- SSPCLKIN, SSPFSSIN and SSPRXD each pass through a 2-flop synchroniser.
- The synchronised SSPCLKIN is rising-edge detected. On each detected edge:
  - If FSS is high: arm the receiver and clear the bit count. If a partial word was in progress, discard it and pulse rx_frame_err.
  - Else if armed: shift in the RXD bit and increment the count.
  - When the count reaches DATA_W: update rx_data, set rx_valid and disarm.
- rx_valid clears on a cycle where rx_ready is high, unless a new word completes in that same cycle, in which case rx_valid stays 1 with the new data.
- A word that completes while rx_valid is high and rx_ready is low overwrites rx_data and sets rx_overrun.
- rx_overrun clears only on reset.
- Edges with FSS low while disarmed are ignored.

Reset values:
- tx_ready 1; rx_valid 0; rx_overrun 0; rx_frame_err 0; rx_data 0.
- SSPCLKOUT 0; SSPFSSOUT 0; SSPTXD 0; SSPOE_B 1.
- TX state IDLE; receiver disarmed; synchronisers 0.
- Reset mid-frame aborts both directions immediately, with no partial rx_valid.

## Timing
- SSPCLKOUT is 0 in IDLE. Within a frame it is low for CLK_DIV cycles, then high for CLK_DIV cycles.
- Accept on cycle T:
  - T+1: SSPFSSOUT=1, SSPOE_B=0, SSPCLKOUT=0.
  - Bit k (k=0..DATA_W-1) is driven from T+1+2·CLK_DIV·(k+1).
  - tx_ready returns to 1 at T+1+2·CLK_DIV·(DATA_W+1). For defaults this is T+37.
- A peer samples SSPTXD on SSPCLKOUT rising edges.
- RX latency: rx_valid is high 3 PCLK cycles after the SSPCLKIN rising edge that carries the last bit (2 synchroniser stages plus the edge register).
- External SSPCLKIN high and low phases are each ≥2 PCLK cycles. SSPRXD and SSPFSSIN are stable around SSPCLKIN rising edges.

## Structure
- Package ssp_pkg holds:
  - the TX state enum (IDLE, FSS, SHIFT);
  - the widths of the bit counter and the divider counter, derived with $clog2;
  - the synchroniser depth constant (2).
- Sub-module ssp_sync: a 2-flop synchroniser with synchronous reset, instantiated three times (SSPCLKIN, SSPFSSIN, SSPRXD).
- The TX FSM with its divider, and the RX shifter, stay in ssp_engine.

## Test plan
- Loopback, defaults: SSPCLKOUT→SSPCLKIN, SSPFSSOUT→SSPFSSIN, SSPTXD→SSPRXD. Send 0xA5 → rx_data=0xA5 and rx_valid=1; tx_ready returns at T+37; SSPOE_B is low only during the frame.
- LSB_FIRST=1, DATA_W=12, CLK_DIV=3, loopback. Send 0x8C1 → SSPTXD bit sequence 1,0,0,0,0,0,1,1,0,0,0,1; rx_data=0x8C1.
- tx_valid held high with 0x11 then 0x22, rx_ready tied 1 → two frames one IDLE cycle apart; two rx_valid pulses with 0x11 and 0x22; rx_overrun=0.
- rx_ready=0, two loopback words 0x3C then 0xC3 → rx_data=0xC3, rx_valid=1, rx_overrun=1 until PRESET.
- External stimulus: FSS pulse, 4 bits, then a second FSS pulse, then 8 bits of 0x5A → one rx_frame_err pulse; rx_data=0x5A.
- PRESET asserted mid-SHIFT → next cycle SSPOE_B=1, SSPFSSOUT=0, SSPCLKOUT=0, tx_ready=1, no rx_valid; the next frame completes normally.
